// File: rtl/pulse_terms.sv
// Per-tap weighted symbol terms for a channel model: LOAD accepts n_terms coefficients,
// RUN shifts symbols into a history and registers +/-coeff per tap. Option: PULSE_TERMS_FILL_MASK_EN.
module pulse_terms #(
  parameter int n_terms    = 8,
  parameter int coeff_bits = 16,
  parameter int term_bits  = 17
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_start,
  input  logic                                cfg_valid,
  input  logic [coeff_bits-1:0]               cfg_data,
  output logic                                cfg_ready,
  input  logic                                sym_valid,
  input  logic                                sym_in,
  output logic [n_terms-1:0][term_bits-1:0]   terms,
  output logic                                terms_valid,
  output logic                                loaded
);

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  localparam int PTR_W = (n_terms > 1) ? $clog2(n_terms) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(n_terms - 1);

  state_t                             state_q;
  logic [PTR_W-1:0]                   ptr_q;
  logic signed [coeff_bits-1:0]       coeff_q [n_terms];
  logic [n_terms-1:0]                 hist_q, hist_d;
  logic [n_terms-1:0][term_bits-1:0]  terms_q, terms_d;
  logic                               terms_valid_q;
  logic                               cfg_ready_q;
  logic                               loaded_q;
  logic signed [term_bits-1:0]        ext_w [n_terms];

`ifdef PULSE_TERMS_FILL_MASK_EN
  logic [n_terms-1:0]                 fill_q, fill_d;
`endif

  // Widening before negation keeps -(-2^(coeff_bits-1)) representable.
  for (genvar k = 0; k < n_terms; k++) begin : g_ext
    assign ext_w[k] = term_bits'(coeff_q[k]);
  end

  // Terms are formed from the post-shift history so they appear one cycle after the strobe.
  always_comb begin
    hist_d = {hist_q[n_terms-2:0], sym_in};
`ifdef PULSE_TERMS_FILL_MASK_EN
    fill_d = {fill_q[n_terms-2:0], 1'b1};
`endif
    terms_d = '0;
    for (int k = 0; k < n_terms; k++) begin
`ifdef PULSE_TERMS_FILL_MASK_EN
      terms_d[k] = fill_d[k] ? (hist_d[k] ? ext_w[k] : -ext_w[k]) : '0;
`else
      terms_d[k] = hist_d[k] ? ext_w[k] : -ext_w[k];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      ptr_q         <= '0;
      hist_q        <= '0;
      terms_q       <= '0;
      terms_valid_q <= 1'b0;
      cfg_ready_q   <= 1'b1;
      loaded_q      <= 1'b0;
      for (int k = 0; k < n_terms; k++) coeff_q[k] <= '0;
`ifdef PULSE_TERMS_FILL_MASK_EN
      fill_q        <= '0;
`endif
    end else begin
      terms_valid_q <= 1'b0;
      if (cfg_start) begin
        // Coefficients are kept; only the load pointer and symbol history restart.
        state_q     <= LOAD;
        ptr_q       <= '0;
        hist_q      <= '0;
        cfg_ready_q <= 1'b1;
        loaded_q    <= 1'b0;
`ifdef PULSE_TERMS_FILL_MASK_EN
        fill_q      <= '0;
`endif
      end else begin
        case (state_q)
          LOAD: begin
            if (cfg_valid) begin
              coeff_q[ptr_q] <= cfg_data;
              if (ptr_q == LAST_PTR) begin
                state_q     <= RUN;
                ptr_q       <= '0;
                cfg_ready_q <= 1'b0;
                loaded_q    <= 1'b1;
              end else begin
                ptr_q <= ptr_q + PTR_W'(1);
              end
            end
          end
          RUN: begin
            if (sym_valid) begin
              hist_q        <= hist_d;
              terms_q       <= terms_d;
              terms_valid_q <= 1'b1;
`ifdef PULSE_TERMS_FILL_MASK_EN
              fill_q        <= fill_d;
`endif
            end
          end
          default: state_q <= LOAD;
        endcase
      end
    end
  end

  assign terms       = terms_q;
  assign terms_valid = terms_valid_q;
  assign cfg_ready   = cfg_ready_q;
  assign loaded      = loaded_q;

endmodule

// File: tb/tb_pulse_terms.sv
// Randomized bench for pulse_terms (4 taps, 8-bit coeffs, 9-bit terms) against a
// queue-based symbol-history model; follows PULSE_TERMS_FILL_MASK_EN like the design.
module tb_pulse_terms;

  localparam int N  = 4;
  localparam int CB = 8;
  localparam int TB = 9;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     cfg_start;
  logic                     cfg_valid;
  logic [CB-1:0]            cfg_data;
  logic                     cfg_ready;
  logic                     sym_valid;
  logic                     sym_in;
  logic [N-1:0][TB-1:0]     terms;
  logic                     terms_valid;
  logic                     loaded;

  pulse_terms #(.n_terms(N), .coeff_bits(CB), .term_bits(TB)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_start   (cfg_start),
    .cfg_valid   (cfg_valid),
    .cfg_data    (cfg_data),
    .cfg_ready   (cfg_ready),
    .sym_valid   (sym_valid),
    .sym_in      (sym_in),
    .terms       (terms),
    .terms_valid (terms_valid),
    .loaded      (loaded)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: symbols live in a queue, newest at index 0.
  int  m_coeff [N];
  bit  m_hist [$];
  int  m_terms [N];
  bit  m_run;
  int  m_ptr;
  bit  m_tv;

  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int tap_term(input int k);
    if (k < m_hist.size()) return m_hist[k] ? m_coeff[k] : -m_coeff[k];
`ifdef PULSE_TERMS_FILL_MASK_EN
    return 0;
`else
    return -m_coeff[k];
`endif
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".terms_valid"}, int'(terms_valid), int'(m_tv));
    check({tag, ".loaded"},      int'(loaded),      int'(m_run));
    check({tag, ".cfg_ready"},   int'(cfg_ready),   int'(!m_run));
    for (int k = 0; k < N; k++)
      check($sformatf("%s.terms[%0d]", tag, k), int'($signed(terms[k])), m_terms[k]);
  endtask

  // Driver: apply one cycle of inputs, advance the model, then check after the edge.
  task automatic cycle(input string tag, input bit cs, input bit cv, input int cd,
                       input bit sv, input bit si);
    cfg_start = cs; cfg_valid = cv; cfg_data = CB'(cd); sym_valid = sv; sym_in = si;
    m_tv = 1'b0;
    if (cs) begin
      m_run = 1'b0; m_ptr = 0; m_hist.delete();
    end else if (!m_run) begin
      if (cv) begin
        m_coeff[m_ptr] = cd;
        if (m_ptr == N - 1) begin m_run = 1'b1; m_ptr = 0; end
        else m_ptr++;
      end
    end else if (sv) begin
      m_hist.push_front(si);
      if (m_hist.size() > N) void'(m_hist.pop_back());
      for (int k = 0; k < N; k++) m_terms[k] = tap_term(k);
      m_tv = 1'b1;
    end
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; cfg_start = 0; cfg_valid = 1; cfg_data = 8'h55; sym_valid = 1; sym_in = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_run = 0; m_ptr = 0; m_tv = 0; m_hist.delete();
    for (int k = 0; k < N; k++) begin m_coeff[k] = 0; m_terms[k] = 0; end
    check_outputs(tag);
  endtask

  // Load four words with random idle gaps and junk symbols that must be ignored.
  task automatic load_coeffs(input string tag, input int c0, input int c1, input int c2, input int c3);
    int c [N];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int k = 0; k < N; k++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++)
        cycle({tag, ".gap"}, 0, 0, int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
      cycle({tag, ".wr"}, 0, 1, c[k], 1'($urandom), 1'($urandom));
    end
  endtask

  function automatic int rand_coeff();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    cfg_start = 0; cfg_valid = 0; cfg_data = '0; sym_valid = 0; sym_in = 0;

    do_reset("reset");
    load_coeffs("load", 10, -20, 30, -128);

    // Single symbol, then idle with cfg_valid junk that RUN must ignore.
    cycle("sym1", 0, 0, 0, 1, 1);
    cycle("idle", 0, 1, 77, 0, 0);
    cycle("idle2", 0, 1, -5, 0, 1);

    cycle("b2b_a", 0, 0, 0, 1, 1);
    cycle("b2b_b", 0, 0, 0, 1, 0);
    cycle("b2b_c", 0, 0, 0, 1, 1);
    cycle("b2b_d", 0, 0, 0, 1, 1);

    for (int i = 0; i < 4; i++) cycle("zeros", 0, 0, 0, 1, 0);

    for (int i = 0; i < 40; i++)
      cycle("rand_run", 0, 1'($urandom), int'($urandom_range(0, 255)),
            1'($urandom_range(0, 3) != 0), 1'($urandom));

    // cfg_start collides with a symbol: symbol dropped, back in LOAD.
    cycle("start_vs_sym", 1, 0, 0, 1, 1);
    load_coeffs("reload", rand_coeff(), -128, rand_coeff(), rand_coeff());
    for (int i = 0; i < 30; i++)
      cycle("rand_run2", 0, 0, 0, 1'($urandom), 1'($urandom));

    // Reset in the middle of a load after two writes.
    cycle("start2", 1, 0, 0, 0, 0);
    cycle("part_wr0", 0, 1, 99, 0, 0);
    cycle("part_wr1", 0, 1, -99, 0, 0);
    do_reset("mid_reset");
    load_coeffs("load3", rand_coeff(), rand_coeff(), rand_coeff(), rand_coeff());
    for (int i = 0; i < 30; i++)
      cycle("rand_run3", 0, 1'($urandom), int'($urandom_range(0, 255)),
            1'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
